// File: rtl/bcd_pkg.sv
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared types, constants and sizing helper for the sequential
//            binary-to-BCD converter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADJ_THRESH  = 4'd5;
  localparam logic [3:0] ADJ_ADD     = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Smallest digit count whose decimal range covers the largest magnitude.
  function automatic int min_digits(input int width, input bit signed_en);
    longint unsigned maxv;
    longint unsigned pow;
    int              d;
    maxv = signed_en ? (64'd1 << (width - 1)) : ((64'd1 << width) - 64'd1);
    pow  = 64'd10;
    d    = 1;
    for (int i = 0; i < 20; i++) begin
      if (pow <= maxv) begin
        pow = pow * 64'd10;
        d   = d + 1;
      end
    end
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
// Module   : bcd_digit_adj
// Brief    : Double-dabble digit correction: adds 3 to a BCD digit >= 5.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= ADJ_THRESH) ? (digit + ADJ_ADD) : digit;

endmodule

`default_nettype wire

// File: rtl/bcd_seq_converter.sv
// ============================================================================
// Module   : bcd_seq_converter
// Brief    : Iterative (one bit per clock) binary-to-BCD converter with
//            valid/ready handshakes. Optional signed input via BCD_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              bin_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
`ifdef BCD_SIGNED_EN
  output logic                          bcd_neg,
`endif
  output logic                          busy
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef BCD_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
      $error("bcd_seq_converter: WIDTH must lie in 2..32");
    end
    if (DIGITS < min_digits(WIDTH, SIGNED_EN)) begin : g_digits_check
      $error("bcd_seq_converter: DIGITS too small for WIDTH");
    end
  endgenerate

  state_t                r_state;
  logic [WIDTH-1:0]      r_shift;
  logic [BCD_W-1:0]      r_bcd;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_out_valid;
  logic [WIDTH-1:0]      w_load;
  logic [BCD_W-1:0]      w_adj;
  logic [BCD_W+WIDTH-1:0] w_next;

`ifdef BCD_SIGNED_EN
  logic r_neg;
  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
  assign w_load  = bin_in[WIDTH-1] ? ((~bin_in) + WIDTH'(1)) : bin_in;
  assign bcd_neg = r_neg;
`else
  assign w_load  = bin_in;
`endif

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit    (r_bcd[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
        .adjusted (w_adj[BCD_DIGIT_W*k +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // The top bit of the adjusted BCD field falls off the shift.
  assign w_next = {w_adj, r_shift} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
`ifdef BCD_SIGNED_EN
      r_neg       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift <= w_load;
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(WIDTH);
            r_state <= SHIFT;
`ifdef BCD_SIGNED_EN
            r_neg   <= bin_in[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          {r_bcd, r_shift} <= w_next;
          r_cnt            <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == SHIFT);
  assign out_valid = r_out_valid;
  assign bcd_out   = r_bcd;

endmodule

`default_nettype wire

// File: tb/tb_bcd_seq_converter.sv
// ============================================================================
// Module   : tb_bcd_seq_converter
// Brief    : Self-checking bench for bcd_seq_converter (WIDTH=8 and WIDTH=5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  bin_in;
  logic [11:0] bcd_out;
  logic        in_valid5, in_ready5, out_valid5, out_ready5, busy5;
  logic [4:0]  bin_in5;
  logic [7:0]  bcd_out5;
`ifdef BCD_SIGNED_EN
  logic        bcd_neg, bcd_neg5;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .bin_in(bin_in), .out_valid(out_valid), .out_ready(out_ready),
    .bcd_out(bcd_out),
`ifdef BCD_SIGNED_EN
    .bcd_neg(bcd_neg),
`endif
    .busy(busy)
  );

  bcd_seq_converter #(.WIDTH(5), .DIGITS(2)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
    .bin_in(bin_in5), .out_valid(out_valid5), .out_ready(out_ready5),
    .bcd_out(bcd_out5),
`ifdef BCD_SIGNED_EN
    .bcd_neg(bcd_neg5),
`endif
    .busy(busy5)
  );

  typedef struct {
    logic [7:0]  v;
    logic [11:0] bcd;
    logic        neg;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain decimal arithmetic on the (optionally signed) value.
  function automatic logic [12:0] model(input int unsigned v, input int w);
    int   x;
    logic neg;
    x   = int'(v);
    neg = 1'b0;
`ifdef BCD_SIGNED_EN
    if (v >= (32'd1 << (w - 1))) x = int'(v) - (1 << w);
    neg = (x < 0);
    if (neg) x = -x;
`endif
    return {neg, 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  task automatic conv(input logic [7:0] v, input logic [11:0] exp_bcd,
                      input logic exp_neg, input string name);
    int l;
    @(negedge clk); in_valid = 1'b1; bin_in = v;
    @(posedge clk); #1; in_valid = 1'b0; bin_in = 8'($urandom);
    l = 0;
    while (!out_valid && l < 40) begin
      chk($sformatf("%s busy", name), busy, 1);
      chk($sformatf("%s in_ready", name), in_ready, 0);
      @(posedge clk); #1; l++;
    end
    chk($sformatf("%s latency", name), l, 8);
    chk($sformatf("%s bcd_out(%0d)", name, v), bcd_out, exp_bcd);
`ifdef BCD_SIGNED_EN
    chk($sformatf("%s bcd_neg", name), bcd_neg, exp_neg);
`else
    chk($sformatf("%s neg_unused", name), 0, 32'(exp_neg));
`endif
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk($sformatf("%s out_valid one cycle", name), out_valid, 0);
    chk($sformatf("%s in_ready after", name), in_ready, 1);
  endtask

  task automatic conv5(input logic [4:0] v);
    int          l;
    logic [12:0] e;
    e = model(32'(v), 5);
    @(negedge clk); in_valid5 = 1'b1; bin_in5 = v;
    @(posedge clk); #1; in_valid5 = 1'b0;
    l = 0;
    while (!out_valid5 && l < 40) begin
      chk("w5 in_ready", in_ready5, 0);
      @(posedge clk); #1; l++;
    end
    chk("w5 latency", l, 5);
    chk($sformatf("w5 bcd_out(%0d)", v), bcd_out5, e[7:0]);
    @(negedge clk); out_ready5 = 1'b1;
    @(posedge clk); #1; out_ready5 = 1'b0;
  endtask

  initial begin
    logic [7:0]  rv;
    logic [12:0] e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bin_in = '0;
    in_valid5 = 1'b0; out_ready5 = 1'b0; bin_in5 = '0;
    #2;
    chk("reset bcd_out", bcd_out, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

`ifdef BCD_SIGNED_EN
    vecs.push_back('{8'h80, 12'h128, 1'b1});
    vecs.push_back('{8'hFF, 12'h001, 1'b1});
    vecs.push_back('{8'd127, 12'h127, 1'b0});
    vecs.push_back('{8'd0, 12'h000, 1'b0});
    vecs.push_back('{8'h9C, 12'h100, 1'b1});
`else
    vecs.push_back('{8'd255, 12'h255, 1'b0});
    vecs.push_back('{8'd0, 12'h000, 1'b0});
    vecs.push_back('{8'd9, 12'h009, 1'b0});
    vecs.push_back('{8'd10, 12'h010, 1'b0});
    vecs.push_back('{8'd99, 12'h099, 1'b0});
    vecs.push_back('{8'd100, 12'h100, 1'b0});
    vecs.push_back('{8'd199, 12'h199, 1'b0});
`endif
    foreach (vecs[i]) conv(vecs[i].v, vecs[i].bcd, vecs[i].neg, "table");

    for (int i = 0; i < 30; i++) begin
      rv = 8'($urandom);
      e  = model(32'(rv), 8);
      conv(rv, e[11:0], e[12], "random");
    end

    // Result held under back-pressure while a new input waits.
    @(negedge clk); in_valid = 1'b1; bin_in = 8'd99;
    @(posedge clk); #1; bin_in = 8'd7;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("hold latency", lat, 8);
    repeat (6) begin
      @(posedge clk); #1;
      chk("hold bcd_out", bcd_out, 12'h099);
      chk("hold in_ready", in_ready, 0);
      chk("hold out_valid", out_valid, 1);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("hold release out_valid", out_valid, 0);
    chk("hold release in_ready", in_ready, 1);
    chk("hold release busy", busy, 0);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("hold next accepted", busy, 1);
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("hold next latency", lat, 8);
    chk("hold next bcd_out", bcd_out, 12'h007);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk); in_valid = 1'b1; bin_in = 8'd200;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst bcd_out", bcd_out, 0);
    chk("async rst busy", busy, 0);
    chk("async rst in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    conv(8'd42, 12'h042, 1'b0, "after reset");

    for (int v = 0; v < 32; v++) conv5(5'(v));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
